// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared op-class codes, FSM encoding and defaults for the complex issue controller
package core_pkg;

    localparam int ROB_W_DEF = 4;

    localparam logic [1:0] OPC_SINGLE = 2'd0;
    localparam logic [1:0] OPC_MUL    = 2'd1;
    localparam logic [1:0] OPC_DIV    = 2'd2;

    localparam logic [1:0] CLS_MUL = 2'b10;
    localparam logic [1:0] CLS_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_e;

    function automatic logic [1:0] op_class(input logic [5:0] aluop);
        case (aluop[5:4])
            CLS_MUL: return OPC_MUL;
            CLS_DIV: return OPC_DIV;
            default: return OPC_SINGLE;
        endcase
    endfunction

endpackage

// File: rtl/complex_age_tracker.sv
// rtl/complex_age_tracker.sv - age pointer between the two RS entries and 2-way oldest-first grant
module complex_age_tracker (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic win_open,
    input  logic rs0_alloc,
    input  logic rs1_alloc,
    input  logic rs0_valid,
    input  logic rs1_valid,
    input  logic rs0_ready,
    input  logic rs1_ready,
    output logic grant0,
    output logic grant1,
    output logic oldest
);

    logic oldest_q;
    logic oldest_d;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (win_open) begin
            if (rs0_ready && (!rs1_ready || !oldest_q)) begin
                grant0 = 1'b1;
            end else if (rs1_ready) begin
                grant1 = 1'b1;
            end
        end
    end

    // A freshly written entry is younger than a survivor that is not leaving this cycle.
    always_comb begin
        oldest_d = oldest_q;
        if (flush) begin
            oldest_d = 1'b0;
        end else if (rs0_alloc && rs1_alloc) begin
            oldest_d = 1'b0;
        end else if (rs0_alloc) begin
            oldest_d = rs1_valid && !grant1;
        end else if (rs1_alloc) begin
            oldest_d = !(rs0_valid && !grant0);
        end else if ((grant0 && !oldest_q) || (grant1 && oldest_q)) begin
            oldest_d = !oldest_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oldest_q <= 1'b0;
        end else begin
            oldest_q <= oldest_d;
        end
    end

    assign oldest = oldest_q;

endmodule

// File: rtl/complex_issue_ctrl.sv
// rtl/complex_issue_ctrl.sv - complex-unit issue FSM, latency counter and writeback hold
// Optional perf counters enabled by COMPLEX_PERF_CNT_EN.
module complex_issue_ctrl
    import core_pkg::*;
#(
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 16,
    parameter int ROB_W   = ROB_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             rs0_alloc,
    input  logic             rs1_alloc,
    input  logic             rs0_ready,
    input  logic             rs1_ready,
    input  logic             rs0_valid,
    input  logic             rs1_valid,
    input  logic [5:0]       rs0_aluop,
    input  logic [5:0]       rs1_aluop,
    input  logic [ROB_W-1:0] rs0_rob,
    input  logic [ROB_W-1:0] rs1_rob,
    input  logic             wb_ready,
`ifdef COMPLEX_PERF_CNT_EN
    output logic [31:0]      perf_issue_cnt,
    output logic [31:0]      perf_wb_stall_cnt,
`endif
    output logic             issue0,
    output logic             issue1,
    output logic             ex_sel,
    output logic             ex_start,
    output logic             busy,
    output logic             wb_valid,
    output logic [ROB_W-1:0] wb_rob,
    output logic             oldest
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ex_sel_q, ex_sel_d;
    logic [ROB_W-1:0]  wb_rob_q, wb_rob_d;
    logic [CNT_W-1:0]  load_cnt;
    logic [5:0]        sel_aluop;
    logic              win_open;
    logic              grant0;
    logic              grant1;
    logic              grant;

    // Gating with rst_n keeps the combinational issue pulses quiet while reset is held.
    assign win_open = rst_n && !flush &&
                      ((state_q == IDLE) || ((state_q == WB) && wb_ready));

    complex_age_tracker u_age (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .win_open  (win_open),
        .rs0_alloc (rs0_alloc),
        .rs1_alloc (rs1_alloc),
        .rs0_valid (rs0_valid),
        .rs1_valid (rs1_valid),
        .rs0_ready (rs0_ready),
        .rs1_ready (rs1_ready),
        .grant0    (grant0),
        .grant1    (grant1),
        .oldest    (oldest)
    );

    assign grant = grant0 || grant1;

    always_comb begin
        sel_aluop = grant1 ? rs1_aluop : rs0_aluop;
        case (op_class(sel_aluop))
            OPC_MUL: load_cnt = CNT_W'(MUL_LAT - 1);
            OPC_DIV: load_cnt = CNT_W'(DIV_LAT - 1);
            default: load_cnt = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ex_sel_d = ex_sel_q;
        wb_rob_d = wb_rob_q;
        if (grant) begin
            ex_sel_d = grant1;
            wb_rob_d = grant1 ? rs1_rob : rs0_rob;
            cnt_d    = load_cnt;
        end
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant) state_d = EXEC;
                end
                EXEC: begin
                    if (cnt_q == '0) state_d = WB;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                WB: begin
                    if (wb_ready) state_d = grant ? EXEC : IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ex_sel_q <= 1'b0;
            wb_rob_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ex_sel_q <= ex_sel_d;
            wb_rob_q <= wb_rob_d;
        end
    end

    assign issue0   = grant0;
    assign issue1   = grant1;
    assign ex_start = grant;
    assign ex_sel   = ex_sel_q;
    assign wb_rob   = wb_rob_q;
    assign busy     = (state_q != IDLE);
    assign wb_valid = (state_q == WB);

`ifdef COMPLEX_PERF_CNT_EN
    logic [31:0] perf_issue_q, perf_issue_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_issue_d = perf_issue_q + {31'd0, grant};
        perf_stall_d = perf_stall_q + {31'd0, (wb_valid && !wb_ready)};
    end

    // Flush deliberately leaves these alone; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issue_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_issue_q <= perf_issue_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_issue_cnt    = perf_issue_q;
    assign perf_wb_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_complex_issue_ctrl.sv
// tb/tb_complex_issue_ctrl.sv - directed self-checking bench for complex_issue_ctrl
module tb_complex_issue_ctrl;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       rs0_alloc, rs1_alloc;
    logic       rs0_ready, rs1_ready;
    logic       rs0_valid, rs1_valid;
    logic [5:0] rs0_aluop, rs1_aluop;
    logic [3:0] rs0_rob, rs1_rob;
    logic       wb_ready;
    logic       issue0, issue1, ex_sel, ex_start, busy, wb_valid, oldest;
    logic [3:0] wb_rob;
`ifdef COMPLEX_PERF_CNT_EN
    logic [31:0] perf_issue_cnt;
    logic [31:0] perf_wb_stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int n_exec;

    complex_issue_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .rs0_alloc (rs0_alloc),
        .rs1_alloc (rs1_alloc),
        .rs0_ready (rs0_ready),
        .rs1_ready (rs1_ready),
        .rs0_valid (rs0_valid),
        .rs1_valid (rs1_valid),
        .rs0_aluop (rs0_aluop),
        .rs1_aluop (rs1_aluop),
        .rs0_rob   (rs0_rob),
        .rs1_rob   (rs1_rob),
        .wb_ready  (wb_ready),
`ifdef COMPLEX_PERF_CNT_EN
        .perf_issue_cnt    (perf_issue_cnt),
        .perf_wb_stall_cnt (perf_wb_stall_cnt),
`endif
        .issue0    (issue0),
        .issue1    (issue1),
        .ex_sel    (ex_sel),
        .ex_start  (ex_start),
        .busy      (busy),
        .wb_valid  (wb_valid),
        .wb_rob    (wb_rob),
        .oldest    (oldest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        flush = 0; wb_ready = 0;
        rs0_alloc = 0; rs1_alloc = 0;
        rs0_ready = 0; rs1_ready = 0;
        rs0_valid = 0; rs1_valid = 0;
        rs0_aluop = 0; rs1_aluop = 0;
        rs0_rob = 0; rs1_rob = 0;
    endtask

    // Count EXEC cycles until wb_valid, starting in the first cycle after issue.
    task automatic wait_wb(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (wb_valid) break;
            n++;
            cyc();
        end
    endtask

    initial begin
        clr_in();
        rst_n = 0;
        rs0_valid = 1; rs0_ready = 1;
        #1;
        repeat (2) cyc();
        check("rst_issue0", issue0, 0);
        check("rst_ex_start", ex_start, 0);
        check("rst_busy", busy, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_rob", wb_rob, 0);
        check("rst_ex_sel", ex_sel, 0);
        check("rst_oldest", oldest, 0);
        clr_in();
        rst_n = 1;
        cyc();

        // single-cycle op from entry 0
        rs0_alloc = 1; rs0_aluop = 6'h01; rs0_rob = 4'd3;
        cyc();
        rs0_alloc = 0; rs0_valid = 1; rs0_ready = 1; #1;
        check("t1_issue0", issue0, 1);
        check("t1_ex_start", ex_start, 1);
        check("t1_issue1", issue1, 0);
        cyc();
        rs0_valid = 0; rs0_ready = 0; #1;
        check("t1_busy", busy, 1);
        check("t1_exec_novalid", wb_valid, 0);
        check("t1_ex_sel", ex_sel, 0);
        cyc();
        check("t1_wb_valid", wb_valid, 1);
        check("t1_wb_rob", wb_rob, 3);
        wb_ready = 1;
        cyc();
        wb_ready = 0; #1;
        check("t1_idle", busy, 0);
        check("t1_wb_drop", wb_valid, 0);

        // age ordering: rs1 older, then back-to-back issue of rs0
        rs1_alloc = 1; rs1_aluop = 6'h01; rs1_rob = 4'd7;
        cyc();
        rs1_alloc = 0; rs1_valid = 1;
        rs0_alloc = 1; rs0_aluop = 6'h02; rs0_rob = 4'd2; #1;
        check("t2_oldest_a", oldest, 1);
        cyc();
        rs0_alloc = 0; rs0_valid = 1; rs0_ready = 1; rs1_ready = 1; #1;
        check("t2_oldest_b", oldest, 1);
        check("t2_issue1", issue1, 1);
        check("t2_issue0_held", issue0, 0);
        cyc();
        rs1_valid = 0; rs1_ready = 0; #1;
        check("t2_exec_noissue", issue0, 0);
        check("t2_ex_sel", ex_sel, 1);
        check("t2_oldest_c", oldest, 0);
        cyc();
        check("t2_wb_valid1", wb_valid, 1);
        check("t2_wb_rob1", wb_rob, 7);
        wb_ready = 1; #1;
        check("t2_b2b_issue0", issue0, 1);
        cyc();
        wb_ready = 0; rs0_valid = 0; rs0_ready = 0; #1;
        check("t2_b2b_busy", busy, 1);
        check("t2_b2b_novalid", wb_valid, 0);
        check("t2_ex_sel0", ex_sel, 0);
        cyc();
        check("t2_wb_rob2", wb_rob, 2);
        wb_ready = 1;
        cyc();
        wb_ready = 0; #1;
        check("t2_idle", busy, 0);

        // MUL latency with a competing ready entry blocked until handshake
        rs0_alloc = 1; rs0_aluop = 6'h20; rs0_rob = 4'd5;
        cyc();
        rs0_alloc = 0; rs0_valid = 1; rs0_ready = 1;
        rs1_alloc = 1; rs1_aluop = 6'h01; rs1_rob = 4'd9; #1;
        check("t3_issue0", issue0, 1);
        cyc();
        rs0_valid = 0; rs0_ready = 0; rs1_alloc = 0; rs1_valid = 1; rs1_ready = 1; #1;
        check("t3_oldest", oldest, 1);
        n_exec = 0;
        for (int i = 0; i < 40; i++) begin
            if (wb_valid) break;
            if (issue1) check("t3_blocked", issue1, 0);
            n_exec++;
            cyc();
        end
        check("t3_mul_exec_cycles", n_exec, 3);
        check("t3_wb_rob", wb_rob, 5);
        check("t3_no_issue_wait", issue1, 0);
        wb_ready = 1; #1;
        check("t3_issue1", issue1, 1);
        cyc();
        wb_ready = 0; rs1_valid = 0; rs1_ready = 0;
        cyc();
        check("t3_wb_rob2", wb_rob, 9);
        wb_ready = 1;
        cyc();
        wb_ready = 0;

        // DIV with writeback stall
        rs0_alloc = 1; rs0_aluop = 6'h30; rs0_rob = 4'hA;
        cyc();
        rs0_alloc = 0; rs0_valid = 1; rs0_ready = 1; #1;
        check("t4_issue0", issue0, 1);
        cyc();
        rs0_valid = 0; rs0_ready = 0; #1;
        wait_wb(n_exec);
        check("t4_div_exec_cycles", n_exec, 16);
        for (int i = 0; i < 4; i++) begin
            check("t4_stall_valid", wb_valid, 1);
            check("t4_stall_rob", wb_rob, 4'hA);
            cyc();
        end
        check("t4_valid5", wb_valid, 1);
        check("t4_rob5", wb_rob, 4'hA);
`ifdef COMPLEX_PERF_CNT_EN
        check("t4_perf_stall", perf_wb_stall_cnt, 4);
        check("t4_perf_issue", perf_issue_cnt, 6);
`endif
        wb_ready = 1;
        cyc();
        wb_ready = 0; #1;
        check("t4_idle", busy, 0);

        // flush during DIV cycle 7
        rs0_alloc = 1; rs0_aluop = 6'h30; rs0_rob = 4'd6;
        cyc();
        rs0_alloc = 0; rs0_valid = 1; rs0_ready = 1;
        rs1_alloc = 1; rs1_aluop = 6'h01; rs1_rob = 4'd11; #1;
        check("t5_issue0", issue0, 1);
        cyc();
        rs0_valid = 0; rs0_ready = 0; rs1_alloc = 0; rs1_valid = 1;
        repeat (6) cyc();
        flush = 1; rs1_ready = 1; #1;
        check("t5_flush_busy", busy, 1);
        check("t5_flush_oldest_pre", oldest, 1);
        check("t5_flush_suppress", issue1, 0);
        cyc();
        flush = 0; #1;
        check("t5_idle", busy, 0);
        check("t5_no_wb", wb_valid, 0);
        check("t5_oldest0", oldest, 0);
        check("t5_issue1_after", issue1, 1);
        cyc();
        rs1_valid = 0; rs1_ready = 0;
        cyc();
        check("t5_wb_valid", wb_valid, 1);
        check("t5_wb_rob", wb_rob, 11);
`ifdef COMPLEX_PERF_CNT_EN
        check("t5_perf_issue", perf_issue_cnt, 8);
`endif
        wb_ready = 1;
        cyc();
        wb_ready = 0;

        // asynchronous reset mid-EXEC
        rs1_alloc = 1; rs1_aluop = 6'h30; rs1_rob = 4'd12;
        cyc();
        rs1_alloc = 0; rs1_valid = 1; rs1_ready = 1; #1;
        check("t6_issue1", issue1, 1);
        cyc();
        rs1_valid = 0; rs1_ready = 0; #1;
        check("t6_ex_sel", ex_sel, 1);
        repeat (2) cyc();
        #2 rst_n = 0;
        #1;
        check("t6_rst_busy", busy, 0);
        check("t6_rst_wb_valid", wb_valid, 0);
        check("t6_rst_ex_sel", ex_sel, 0);
        check("t6_rst_wb_rob", wb_rob, 0);
        check("t6_rst_oldest", oldest, 0);
`ifdef COMPLEX_PERF_CNT_EN
        check("t6_rst_perf", perf_issue_cnt, 0);
`endif
        cyc();
        rst_n = 1;
        cyc();
        rs0_alloc = 1; rs0_aluop = 6'h01; rs0_rob = 4'd1;
        cyc();
        rs0_alloc = 0; rs0_valid = 1; rs0_ready = 1; #1;
        check("t6_post_issue0", issue0, 1);
        cyc();
        rs0_valid = 0; rs0_ready = 0;
        cyc();
        check("t6_post_wb_valid", wb_valid, 1);
        check("t6_post_wb_rob", wb_rob, 1);
        wb_ready = 1;
        cyc();
        wb_ready = 0; #1;
        check("t6_post_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
